// File: rtl/wb_cmd_initiator_pkg.sv
// Shared types and constants for the Wishbone command initiator and its timer.
package wb_cmd_initiator_pkg;

    localparam int unsigned WB_SEL_W  = 4;
    localparam int unsigned WB_DATA_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_REQ     = 3'd1,
        ST_WAIT    = 3'd2,
        ST_BACKOFF = 3'd3,
        ST_RSP     = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        RSP_OK              = 2'b00,
        RSP_ERR             = 2'b01,
        RSP_TIMEOUT         = 2'b10,
        RSP_RETRY_EXHAUSTED = 2'b11
    } rsp_status_e;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/wb_cmd_initiator_if.sv
// Command/response stream plus Wishbone B4 pipelined master signals.
interface wb_cmd_initiator_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) ();
    import wb_cmd_initiator_pkg::*;

    logic                  cmd_valid_i;
    logic                  cmd_ready_o;
    logic                  cmd_we_i;
    logic [ADDR_WIDTH-1:0] cmd_adr_i;
    logic [WB_SEL_W-1:0]   cmd_sel_i;
    logic [DATA_WIDTH-1:0] cmd_dat_i;

    logic                  rsp_valid_o;
    logic                  rsp_ready_i;
    logic [DATA_WIDTH-1:0] rsp_dat_o;
    logic [1:0]            rsp_status_o;

    logic                  wb_cyc_o;
    logic                  wb_stb_o;
    logic                  wb_we_o;
    logic [ADDR_WIDTH-1:0] wb_adr_o;
    logic [WB_SEL_W-1:0]   wb_sel_o;
    logic [DATA_WIDTH-1:0] wb_dat_o;
    logic [DATA_WIDTH-1:0] wb_dat_i;
    logic                  wb_ack_i;
    logic                  wb_err_i;
    logic                  wb_rty_i;
    logic                  wb_stall_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
        input  rsp_ready_i,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i,
        output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_dat_i,
        output rsp_ready_i,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i, wb_stall_i,
        input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_status_o,
        input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o
    );

endinterface

// File: rtl/wb_cmd_timer.sv
// Loadable down-counter; o_expired is high while the count sits at zero.
module wb_cmd_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_expired
);

    logic [WIDTH-1:0] r_cnt;

    // Load wins over counting; the count holds at zero once expired.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - WIDTH'(1);
        end
    end

    assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/wb_cmd_initiator.sv
// Single-outstanding Wishbone B4 pipelined initiator: one command in, one
// bus cycle (with retry/backoff and timeout), one status response out.
module wb_cmd_initiator
    import wb_cmd_initiator_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned MAX_RETRY  = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    wb_cmd_initiator_if.master bus
);

    localparam int unsigned TMR_W   = cnt_width(TIMEOUT);
    localparam int unsigned RETRY_W = cnt_width(MAX_RETRY);

    state_e                r_state;
    state_e                w_next;

    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_adr;
    logic [WB_SEL_W-1:0]   r_sel;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [DATA_WIDTH-1:0] r_rsp_dat;
    rsp_status_e           r_rsp_status;
    logic [RETRY_W-1:0]    r_retry_cnt;

    logic                  w_accept;
    logic                  w_in_cycle;
    logic                  w_retry_ok;
    logic                  w_expired;
    logic                  w_tmr_load;
    logic                  w_tmr_en;
    logic                  w_cyc;
    logic                  w_stb;
    logic                  w_cmd_ready;
    logic                  w_rsp_valid;
    logic                  w_run;

    assign w_accept   = (r_state == ST_IDLE) && bus.cmd_valid_i;
    assign w_in_cycle = (r_state == ST_REQ) || (r_state == ST_WAIT);
    assign w_retry_ok = (r_retry_cnt < RETRY_W'(MAX_RETRY));
    assign w_run      = ~rst_i;

    wb_cmd_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_tmr_load),
        .i_load_val (TMR_W'(TIMEOUT - 1)),
        .i_en       (w_tmr_en),
        .o_expired  (w_expired)
    );

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state; terminations rank err > rty > ack > timeout, and any of
    // them in REQ completes the cycle even while stall is high.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (bus.cmd_valid_i) w_next = ST_REQ;
            end
            ST_REQ, ST_WAIT: begin
                if (bus.wb_err_i) begin
                    w_next = ST_RSP;
                end else if (bus.wb_rty_i) begin
                    w_next = w_retry_ok ? ST_BACKOFF : ST_RSP;
                end else if (bus.wb_ack_i || w_expired) begin
                    w_next = ST_RSP;
                end else if ((r_state == ST_REQ) && !bus.wb_stall_i) begin
                    w_next = ST_WAIT;
                end
            end
            ST_BACKOFF: w_next = ST_REQ;
            ST_RSP: begin
                if (bus.rsp_ready_i) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Control outputs decoded purely from the state register.
    always_comb begin
        w_cyc       = 1'b0;
        w_stb       = 1'b0;
        w_cmd_ready = 1'b0;
        w_rsp_valid = 1'b0;
        w_tmr_load  = 1'b0;
        w_tmr_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
                w_tmr_load  = 1'b1;
            end
            ST_REQ: begin
                w_cyc    = 1'b1;
                w_stb    = 1'b1;
                w_tmr_en = 1'b1;
            end
            ST_WAIT: begin
                w_cyc    = 1'b1;
                w_tmr_en = 1'b1;
            end
            ST_BACKOFF: w_tmr_load  = 1'b1;
            ST_RSP:     w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Command latch, retry counter and response capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_we         <= 1'b0;
            r_adr        <= '0;
            r_sel        <= '0;
            r_dat        <= '0;
            r_rsp_dat    <= '0;
            r_rsp_status <= RSP_OK;
            r_retry_cnt  <= '0;
        end else begin
            if (w_accept) begin
                r_we        <= bus.cmd_we_i;
                r_adr       <= bus.cmd_adr_i;
                r_sel       <= bus.cmd_sel_i;
                r_dat       <= bus.cmd_dat_i;
                r_retry_cnt <= '0;
            end
            if (w_in_cycle) begin
                if (bus.wb_err_i) begin
                    r_rsp_status <= RSP_ERR;
                    r_rsp_dat    <= '0;
                end else if (bus.wb_rty_i) begin
                    if (w_retry_ok) begin
                        r_retry_cnt <= r_retry_cnt + RETRY_W'(1);
                    end else begin
                        r_rsp_status <= RSP_RETRY_EXHAUSTED;
                        r_rsp_dat    <= '0;
                    end
                end else if (bus.wb_ack_i) begin
                    r_rsp_status <= RSP_OK;
                    r_rsp_dat    <= r_we ? '0 : bus.wb_dat_i;
                end else if (w_expired) begin
                    r_rsp_status <= RSP_TIMEOUT;
                    r_rsp_dat    <= '0;
                end
            end
        end
    end

    // Every output is forced low while reset is held, before the first edge.
    assign bus.cmd_ready_o  = w_run & w_cmd_ready;
    assign bus.rsp_valid_o  = w_run & w_rsp_valid;
    assign bus.rsp_dat_o    = w_run ? r_rsp_dat : '0;
    assign bus.rsp_status_o = w_run ? r_rsp_status : 2'b00;
    assign bus.wb_cyc_o     = w_run & w_cyc;
    assign bus.wb_stb_o     = w_run & w_stb;
    assign bus.wb_we_o      = w_run & r_we;
    assign bus.wb_adr_o     = w_run ? r_adr : '0;
    assign bus.wb_sel_o     = w_run ? r_sel : '0;
    assign bus.wb_dat_o     = w_run ? r_dat : '0;

endmodule

// File: tb/tb_wb_cmd_initiator.sv
// Randomised scoreboard bench for wb_cmd_initiator with a scripted Wishbone responder.
module tb_wb_cmd_initiator;
    import wb_cmd_initiator_pkg::*;

    localparam int TMO   = 10;
    localparam int MAXR  = 3;
    localparam int K_ACK = 0;
    localparam int K_ERR = 1;
    localparam int K_SIL = 2;

    typedef struct {
        logic [1:0]  status;
        logic [31:0] dat;
        int          att;
        int          len;
        int          stb;
        bit          silent;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_cmd_initiator_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    wb_cmd_initiator #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (TMO),
        .MAX_RETRY  (MAXR)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    exp_t        exp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_mem [4];
    logic [31:0] slv_mem   [4];
    int          cfg_kind, cfg_stall, cfg_ackdly, cfg_rty;
    int          att_cnt, last_len, stb_cnt;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h @%0t", name, act, req, $time);
        end
    endtask

    // Expected outcome of one command from the responder script and a word store.
    function automatic exp_t ref_model(input bit we, input int idx, input logic [3:0] sel,
                                       input logic [31:0] dat, input int kind, input int stall,
                                       input int ackdly, input int rty);
        exp_t e;
        e.dat = 32'h0; e.stb = stall + 1; e.silent = 1'b0;
        e.len = stall + ackdly + 1;
        if (rty > MAXR) begin
            e.status = 2'b11;
            e.att    = MAXR + 1;
        end else begin
            e.att = rty + 1;
            if (kind == K_ACK) begin
                e.status = 2'b00;
                if (we) begin
                    for (int b = 0; b < 4; b++)
                        if (sel[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
                end else begin
                    e.dat = model_mem[idx];
                end
            end else if (kind == K_ERR) begin
                e.status = 2'b01;
            end else begin
                e.status = 2'b10;
                e.len    = TMO;
                e.silent = 1'b1;
            end
        end
        return e;
    endfunction

    task automatic issue(input bit we, input int idx, input logic [3:0] sel, input logic [31:0] dat,
                         input int kind, input int stall, input int ackdly, input int rty,
                         input bit push);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.cmd_ready_o) break;
            n++;
            if (n > 300) begin
                chk("cmd_ready_timeout", 0, 1);
                return;
            end
        end
        cfg_kind = kind; cfg_stall = stall; cfg_ackdly = ackdly; cfg_rty = rty;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = 32'(idx * 4);
        bus.cmd_sel_i   = sel;
        bus.cmd_dat_i   = dat;
        @(posedge clk);
        #1;
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i    = 1'b0;
        bus.cmd_dat_i   = $urandom;
        if (push) exp_q.push_back(ref_model(we, idx, sel, dat, kind, stall, ackdly, rty));
    endtask

    // Wishbone responder: stalls, then terminates per the current script.
    initial begin
        bit prev_cyc;
        int t, gap, late, idx;
        prev_cyc = 1'b0; t = 0; gap = 0; late = 0; idx = 0;
        att_cnt = 0; last_len = 0; stb_cnt = 0;
        for (int i = 0; i < 4; i++) slv_mem[i] = 32'h0;
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        bus.wb_stall_i = 1'b0; bus.wb_dat_i = 32'h0;
        forever begin
            @(negedge clk);
            bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
            bus.wb_stall_i = 1'b0; bus.wb_dat_i = 32'h0;
            if (rst) begin
                prev_cyc = 1'b0; late = 0;
                continue;
            end
            if (bus.cmd_ready_o) att_cnt = 0;
            if (bus.wb_cyc_o) begin
                if (!prev_cyc) begin
                    if (att_cnt > 0) chk("backoff_gap", gap, 1);
                    att_cnt++; t = 0; stb_cnt = 0;
                end else begin
                    t++;
                end
                if (bus.wb_stb_o) stb_cnt++;
                last_len = t + 1;
                bus.wb_stall_i = (t < cfg_stall);
                if (t == cfg_stall + cfg_ackdly) begin
                    idx = int'(bus.wb_adr_o[3:2]);
                    if (att_cnt <= cfg_rty) begin
                        bus.wb_rty_i = 1'b1;
                    end else if (cfg_kind == K_ACK) begin
                        bus.wb_ack_i = 1'b1;
                        if (bus.wb_we_o) begin
                            for (int b = 0; b < 4; b++)
                                if (bus.wb_sel_o[b]) slv_mem[idx][8*b +: 8] = bus.wb_dat_o[8*b +: 8];
                        end else begin
                            bus.wb_dat_i = slv_mem[idx];
                        end
                    end else if (cfg_kind == K_ERR) begin
                        bus.wb_err_i = 1'b1;
                    end
                end
            end else begin
                if (prev_cyc) begin
                    gap  = 0;
                    late = (cfg_kind == K_SIL && att_cnt > cfg_rty) ? 1 : 0;
                end
                gap++;
                if (late > 0) begin
                    late++;
                    if (late == 4) begin
                        bus.wb_ack_i = 1'b1;
                        bus.wb_dat_i = 32'hBAD0_0ACC;
                        late = 0;
                    end
                end
            end
            prev_cyc = bus.wb_cyc_o;
        end
    end

    // Monitor: pops the scoreboard whenever a response is presented.
    initial begin
        bit          have;
        int          wait_n;
        exp_t        cur;
        logic [33:0] held;
        have = 1'b0; wait_n = 0; held = '0;
        bus.rsp_ready_i = 1'b0;
        forever begin
            @(negedge clk);
            bus.rsp_ready_i = 1'b0;
            if (rst) begin
                have = 1'b0;
                continue;
            end
            chk("ready_valid_exclusive", longint'(bus.cmd_ready_o && bus.rsp_valid_o), 0);
            if (bus.rsp_valid_o) begin
                if (!have) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_rsp", 1, 0);
                        bus.rsp_ready_i = 1'b1;
                        continue;
                    end
                    cur    = exp_q.pop_front();
                    have   = 1'b1;
                    wait_n = cur.silent ? 4 : int'($urandom_range(0, 3));
                    held   = {bus.rsp_status_o, bus.rsp_dat_o};
                end else begin
                    chk("rsp_stable", longint'({bus.rsp_status_o, bus.rsp_dat_o}), longint'(held));
                end
                if (wait_n == 0) begin
                    bus.rsp_ready_i = 1'b1;
                    chk("rsp_status", bus.rsp_status_o, cur.status);
                    chk("rsp_dat", bus.rsp_dat_o, cur.dat);
                    chk("attempts", att_cnt, cur.att);
                    chk("cyc_len", last_len, cur.len);
                    chk("stb_len", stb_cnt, cur.stb);
                    have = 1'b0;
                end else begin
                    wait_n--;
                end
            end
        end
    end

    function automatic logic any_out();
        return |{bus.cmd_ready_o, bus.rsp_valid_o, bus.rsp_dat_o, bus.rsp_status_o,
                 bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o, bus.wb_sel_o,
                 bus.wb_dat_o};
    endfunction

    initial begin
        int n;
        for (int i = 0; i < 4; i++) model_mem[i] = 32'h0;
        cfg_kind = K_ACK; cfg_stall = 0; cfg_ackdly = 0; cfg_rty = 0;
        bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = 32'h0;
        bus.cmd_sel_i = 4'h0; bus.cmd_dat_i = 32'h0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_zero", any_out(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_reset", bus.cmd_ready_o, 1);

        // Two-register traffic, WAIT path, err, retry exhaustion/recovery, timeout.
        issue(1'b1, 0, 4'hF, 32'hDEADBEEF, K_ACK, 2, 0, 0, 1'b1);
        issue(1'b0, 0, 4'hF, 32'h0,        K_ACK, 1, 0, 0, 1'b1);
        issue(1'b1, 1, 4'hF, 32'h12345678, K_ACK, 1, 1, 0, 1'b1);
        issue(1'b0, 0, 4'hF, 32'h0,        K_ACK, 0, 0, 0, 1'b1);
        issue(1'b0, 1, 4'hF, 32'h0,        K_ERR, 0, 0, 0, 1'b1);
        issue(1'b1, 2, 4'hF, 32'hAAAA5555, K_ACK, 0, 0, 4, 1'b1);
        issue(1'b0, 2, 4'hF, 32'h0,        K_ACK, 1, 0, 1, 1'b1);
        issue(1'b0, 3, 4'hF, 32'h0,        K_SIL, 0, 0, 0, 1'b1);

        for (int i = 0; i < 60; i++) begin
            int k, kind, rty;
            k    = int'($urandom_range(0, 9));
            kind = (k < 7) ? K_ACK : ((k < 8) ? K_ERR : K_SIL);
            rty  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4)) : 0;
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  4'($urandom_range(1, 15)), $urandom, kind,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), rty, 1'b1);
        end

        // Reset while waiting for a termination; no response may follow.
        issue(1'b0, 3, 4'hF, 32'h0, K_SIL, 0, 0, 0, 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.wb_cyc_o && !bus.wb_stb_o) break;
            n++;
            if (n > 20) begin
                chk("reach_wait_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_mid_wait_zero", any_out(), 0);
        @(posedge clk);
        @(negedge clk);
        chk("reset_held_zero", any_out(), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("cmd_ready_after_abort", bus.cmd_ready_o, 1);
        repeat (20) @(negedge clk);
        issue(1'b0, 0, 4'hF, 32'h0, K_ACK, 1, 1, 0, 1'b1);

        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", exp_q.size(), 0);
        repeat (6) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
